// File: rtl/tinyalu_pkg.sv
// TinyALU shared types: operation codes, driver FSM states,
// and the command bundle queued between cmd port and ALU bus.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    fun_op = 3'b101,
    rst_op = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    NOP   = 3'd2,
    RST   = 3'd3,
    RSP   = 3'd4
  } driver_state_t;

  typedef struct packed {
    operation_t op;
    bit [7:0]   a;
    bit [7:0]   b;
  } alu_cmd_t;

endpackage

// File: rtl/tinyalu_cmd_driver_if.sv
// Command/response handshakes plus TinyALU pin bus.
// master = driver side, slave = stimulus side and ALU.
interface tinyalu_cmd_driver_if;
  import tinyalu_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  operation_t cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;

  logic        rsp_valid;
  logic        rsp_ready;
  operation_t  rsp_op;
  logic [15:0] rsp_result;
  logic        rsp_timeout;

  logic        alu_start;
  operation_t  alu_op;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_reset_n;

  logic busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output rsp_valid, rsp_op, rsp_result,
    output rsp_timeout,
    input  rsp_ready,
    output alu_start, alu_op, alu_A, alu_B,
    output alu_reset_n,
    input  alu_done, alu_result,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  rsp_valid, rsp_op, rsp_result,
    input  rsp_timeout,
    output rsp_ready,
    input  alu_start, alu_op, alu_A, alu_B,
    input  alu_reset_n,
    output alu_done, alu_result,
    input  busy
  );

endinterface

// File: rtl/tinyalu_cmd_fifo.sv
// Register-array FIFO of alu_cmd_t.
// Ports: clk, rst_n, push/wdata, pop/rdata, full, empty, count.
module tinyalu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  alu_cmd_t      wdata,
  input  logic          pop,
  output alu_cmd_t      rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  alu_cmd_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// TinyALU bus initiator: queues commands, runs them on the
// ALU pins one at a time and returns one response each.
// Ports: clk, reset_n, bus (cmd in, rsp out, ALU pin bus).
module tinyalu_cmd_driver
  import tinyalu_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16,
  parameter int RST_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  tinyalu_cmd_driver_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);

  driver_state_t state;
  alu_cmd_t      head;
  alu_cmd_t      wdata;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  operation_t    op_q;
  logic [7:0]    a_q;
  logic [7:0]    b_q;
  logic          start_q;
  logic          rst_active;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;
  logic [15:0]   res_q;
  logic          tmo_q;

  assign wdata = '{op: bus.cmd_op,
                   a:  bus.cmd_a,
                   b:  bus.cmd_b};
  assign push  = bus.cmd_valid && bus.cmd_ready;
  assign pop   = (state == IDLE) && !empty;

  tinyalu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      op_q       <= no_op;
      a_q        <= '0;
      b_q        <= '0;
      start_q    <= 1'b0;
      rst_active <= 1'b0;
      tcnt       <= '0;
      rcnt       <= '0;
      res_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            op_q  <= head.op;
            a_q   <= head.a;
            b_q   <= head.b;
            tcnt  <= '0;
            rcnt  <= '0;
            res_q <= '0;
            tmo_q <= 1'b0;
            unique case (1'b1)
              (head.op == no_op): begin
                start_q <= 1'b1;
                state   <= NOP;
              end
              (head.op == rst_op): begin
                rst_active <= 1'b1;
                state      <= RST;
              end
              default: begin
                start_q <= 1'b1;
                state   <= ISSUE;
              end
            endcase
          end
        end
        ISSUE: begin
          // done is checked first so it wins a tie
          if (bus.alu_done) begin
            res_q   <= bus.alu_result;
            start_q <= 1'b0;
            state   <= RSP;
          end else if (tcnt == T_LAST) begin
            start_q    <= 1'b0;
            tmo_q      <= 1'b1;
            rst_active <= 1'b1;
            state      <= RST;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        NOP: begin
          start_q <= 1'b0;
          state   <= RSP;
        end
        RST: begin
          if (rcnt == R_LAST) begin
            rst_active <= 1'b0;
            state      <= RSP;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        RSP: begin
          if (bus.rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.rsp_valid   = (state == RSP);
  assign bus.rsp_op      = op_q;
  assign bus.rsp_result  = res_q;
  assign bus.rsp_timeout = tmo_q;
  assign bus.alu_start   = start_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_A       = a_q;
  assign bus.alu_B       = b_q;
  assign bus.alu_reset_n = reset_n && !rst_active;
  assign bus.busy        = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Directed bench for tinyalu_cmd_driver with a simple
// TinyALU model (fixed 3-cycle done, or never done).
module tb_tinyalu_cmd_driver;
  import tinyalu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  tinyalu_cmd_driver_if bus ();

  tinyalu_cmd_driver #(
    .DEPTH      (4),
    .TIMEOUT    (16),
    .RST_CYCLES (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic        tmo;
  } rsp_t;

  rsp_t rsp_q [$];

  bit   hang = 1'b0;
  int   scnt = 0;
  int   sl = 0, last_sl = 0;
  int   rl = 0, last_rl = 0;
  int   ab_chg = 0;
  logic [2:0] st_op = '0;
  logic       prev_start = 1'b0;
  logic [7:0] prev_a = '0, prev_b = '0;
  logic [2:0] prev_op = '0;

  logic [15:0] exp_res [6] = '{16'd3, 16'd7, 16'd11,
                               16'd15, 16'd19, 16'd23};

  // ALU model: done after start has been high 3 cycles
  always @(negedge clk) begin
    if (bus.alu_start) scnt = scnt + 1;
    else scnt = 0;
    bus.alu_done = !hang && (scnt == 3);
    case (bus.alu_op)
      add_op:  bus.alu_result = {8'h00, bus.alu_A} + {8'h00, bus.alu_B};
      and_op:  bus.alu_result = {8'h00, bus.alu_A & bus.alu_B};
      xor_op:  bus.alu_result = {8'h00, bus.alu_A ^ bus.alu_B};
      mul_op:  bus.alu_result = bus.alu_A * bus.alu_B;
      default: bus.alu_result = 16'h0000;
    endcase
  end

  // Monitor: responses, pulse lengths, operand stability
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready)
      rsp_q.push_back('{bus.rsp_op, bus.rsp_result,
                        bus.rsp_timeout});
    if (bus.alu_start) begin
      if (!prev_start) st_op = bus.alu_op;
      if (prev_start && (bus.alu_A != prev_a ||
          bus.alu_B != prev_b || bus.alu_op != prev_op))
        ab_chg = ab_chg + 1;
      sl = sl + 1;
    end else begin
      if (sl != 0) last_sl = sl;
      sl = 0;
    end
    prev_start = bus.alu_start;
    prev_a     = bus.alu_A;
    prev_b     = bus.alu_B;
    prev_op    = bus.alu_op;
    if (reset_n && !bus.alu_reset_n) begin
      rl = rl + 1;
    end else begin
      if (rl != 0) last_rl = rl;
      rl = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input operation_t op,
                          input logic [7:0] a,
                          input logic [7:0] b);
    bit acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (!acc) chk("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 400; i++) begin
      if (rsp_q.size() >= n) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("rsp_count", rsp_q.size(), n);
  endtask

  task automatic chk_rsp(input string tag, input int idx,
                         input logic [2:0] op,
                         input logic [15:0] res,
                         input logic tmo);
    if (idx < rsp_q.size()) begin
      chk({tag, "_op"},  rsp_q[idx].op,  op);
      chk({tag, "_res"}, rsp_q[idx].res, res);
      chk({tag, "_tmo"}, rsp_q[idx].tmo, tmo);
    end else begin
      chk({tag, "_missing"}, rsp_q.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = no_op;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_start",     bus.alu_start,   0);
    chk("rst_rsp_valid", bus.rsp_valid,   0);
    chk("rst_busy",      bus.busy,        0);
    chk("rst_cmd_ready", bus.cmd_ready,   1);
    chk("rst_alu_rstn",  bus.alu_reset_n, 0);
    chk("rst_alu_bus",   {bus.alu_op, bus.alu_A, bus.alu_B}, 0);
    reset_n = 1'b1;
    #1;
    chk("rel_alu_rstn",  bus.alu_reset_n, 1);
    @(posedge clk);
    #1;

    // 1: add with latency check
    rsp_q.delete();
    push_cmd(add_op, 8'hFF, 8'h01);
    chk("t1_lat_e1", bus.alu_start, 0);
    @(posedge clk);
    #1;
    chk("t1_lat_e2", bus.alu_start, 1);
    wait_rsp(1);
    chk("t1_start_len", last_sl, 3);
    chk_rsp("t1", 0, add_op, 16'h0100, 1'b0);

    // 2: mul, operands stable while start high
    rsp_q.delete();
    ab_chg = 0;
    push_cmd(mul_op, 8'hFF, 8'hFF);
    wait_rsp(1);
    chk("t2_start_len", last_sl, 3);
    chk("t2_ab_stable", ab_chg, 0);
    chk_rsp("t2", 0, mul_op, 16'hFE01, 1'b0);

    // 3: back-pressure fills the FIFO
    rsp_q.delete();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_cmd(add_op, 8'(2 * i + 1), 8'(2 * i + 2));
    chk("t3_full_ready", bus.cmd_ready, 0);
    fork
      push_cmd(add_op, 8'd11, 8'd12);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("t3_held_valid", bus.rsp_valid, 1);
        chk("t3_stall_ready", bus.cmd_ready, 0);
        chk("t3_none_yet", rsp_q.size(), 0);
        chk("t3_busy", bus.busy, 1);
        bus.rsp_ready = 1'b1;
      end
    join
    wait_rsp(6);
    for (int i = 0; i < 6; i++)
      chk_rsp($sformatf("t3_%0d", i), i, add_op,
              exp_res[i], 1'b0);

    // 4: timeout
    rsp_q.delete();
    hang    = 1'b1;
    last_sl = 0;
    last_rl = 0;
    push_cmd(xor_op, 8'h5A, 8'hA5);
    wait_rsp(1);
    hang = 1'b0;
    chk("t4_start_len", last_sl, 16);
    chk("t4_rstn_len", last_rl, 2);
    chk_rsp("t4", 0, xor_op, 16'h0000, 1'b1);

    // 5: rst_op then no_op
    rsp_q.delete();
    last_sl = 0;
    last_rl = 0;
    st_op   = 3'b111;
    push_cmd(rst_op, 8'h12, 8'h34);
    push_cmd(no_op, 8'h56, 8'h78);
    wait_rsp(2);
    chk("t5_rstn_len", last_rl, 2);
    chk("t5_start_len", last_sl, 1);
    chk("t5_start_op", st_op, 0);
    chk_rsp("t5a", 0, rst_op, 16'h0000, 1'b0);
    chk_rsp("t5b", 1, no_op, 16'h0000, 1'b0);

    // 6: reset during ISSUE with two queued
    rsp_q.delete();
    hang = 1'b1;
    push_cmd(and_op, 8'hF0, 8'h3C);
    push_cmd(and_op, 8'h0F, 8'hFF);
    push_cmd(and_op, 8'hAA, 8'h55);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_in_issue", bus.alu_start, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_start_drop", bus.alu_start, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_cmd_ready", bus.cmd_ready, 1);
    chk("t6_alu_rstn", bus.alu_reset_n, 0);
    repeat (2) @(posedge clk);
    #1;
    rsp_q.delete();
    hang    = 1'b0;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t6_no_rsp", rsp_q.size(), 0);
    chk("t6_idle_busy", bus.busy, 0);
    chk("t6_idle_start", bus.alu_start, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tinyalu_cmd_driver.md
Name: tinyalu_cmd_driver

Overview:
Bus initiator for the TinyALU. It accepts operation commands through a valid/ready port and buffers them in a small FIFO. It drives them one at a time onto the ALU start/op/A/B interface, waits for done, and returns one response per command on a valid/ready port. It sits between stimulus/software-side logic and the TinyALU, and replaces direct pin-wiggling of the ALU bus.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 16, max cycles alu_start held without alu_done before abort
RST_CYCLES, 2, cycles alu_reset_n held low for rst_op or after timeout

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_op  in  3  operation_t
cmd_a  in  8  operand A
cmd_b  in  8  operand B
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_op  out  3  operation_t of completed command
rsp_result  out  16  ALU result, or 0
rsp_timeout  out  1  command aborted by timeout
alu_start  out  1  TinyALU start
alu_op  out  3  TinyALU op
alu_A  out  8  TinyALU A
alu_B  out  8  TinyALU B
alu_done  in  1  TinyALU done
alu_result  in  16  TinyALU result
alu_reset_n  out  1  TinyALU reset, = reset_n AND NOT rst_active
busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset (async, reset_n low): FIFO flushed, FSM=IDLE, counters 0. alu_start/alu_op/alu_A/alu_B/rsp_*/busy all 0. cmd_ready=1. alu_reset_n=0 (follows reset_n).
- Reset mid-operation: alu_start drops immediately. In-flight command and queued commands are discarded. No response is produced for them.
- FIFO: push on cmd_valid&&cmd_ready. cmd_ready=!full, combinational from registered count. Push and pop in the same cycle are both legal when not full. A push while full is not accepted.
- FSM states: IDLE, ISSUE, NOP, RST, RSP.
- IDLE: if FIFO non-empty, pop at this edge and load alu_op/A/B registers. Next state by op:
  - no_op -> NOP.
  - rst_op -> RST.
  - add/and/xor/mul/fun -> ISSUE, alu_start=1 from the same edge.
  - Latency: alu_start rises on the 2nd edge after the accepting push edge, when idle and the FIFO is empty.
- ISSUE: alu_start, alu_op, alu_A, alu_B held stable. Timeout counter increments each cycle.
  - alu_done sampled high: capture alu_result, alu_start=0, rsp_timeout=0 -> RSP.
  - Counter reaches TIMEOUT with no done (alu_start high exactly TIMEOUT cycles): alu_start=0, result=0, rsp_timeout=1 -> RST.
  - Done arriving on the same edge as the timeout wins; it counts as normal completion.
- NOP: alu_start high for exactly one cycle with alu_op=no_op. No done is expected. Result=0 -> RSP.
- RST: rst_active=1 for RST_CYCLES cycles, so alu_reset_n is low and alu_start=0. Then -> RSP. For rst_op, result=0 and rsp_timeout=0. For the timeout path, the flag is kept.
- RSP: rsp_valid=1. rsp_op, rsp_result and rsp_timeout held stable until rsp_ready. On handshake -> IDLE, rsp_valid=0 next cycle.
  - alu_start is therefore low for at least 2 cycles between consecutive ALU commands.
- alu_done seen outside ISSUE: ignored.
- Every accepted command yields exactly one response, in order.

Decomposition:
- tinyalu_pkg already holds operation_t.
- Add to tinyalu_pkg: driver_state_t enum (IDLE, ISSUE, NOP, RST, RSP), and a packed struct alu_cmd_t {operation_t op; bit[7:0] a; bit[7:0] b}.
- Sub-module: tinyalu_cmd_fifo, a register-array FIFO of alu_cmd_t parameterised by DEPTH, with full/empty/count outputs.

Test Plan:
1. add_op A=8'hFF B=8'h01; model asserts done 3 cycles after start -> alu_start high 3 cycles; rsp_result=16'h0100, rsp_op=add_op, rsp_timeout=0.
2. mul_op A=8'hFF B=8'hFF, done after 3 cycles -> rsp_result=16'hFE01; alu_A/alu_B stable throughout ISSUE.
3. rsp_ready=0 and 6 back-to-back pushes (DEPTH=4) -> cmd 1 held in RSP, cmds 2-5 fill the FIFO, cmd_ready=0, cmd 6 stalls. Then raise rsp_ready -> 6 responses in push order.
4. xor_op with a model that never asserts done -> alu_start high exactly 16 cycles; alu_reset_n low 2 cycles; response rsp_timeout=1, rsp_result=0.
5. rst_op then no_op -> alu_reset_n low 2 cycles; one-cycle alu_start with op=000; two responses, both result 0, timeout 0.
6. reset_n low during ISSUE of and_op with 2 commands queued -> alu_start=0 asynchronously, busy=0, cmd_ready=1; no responses after release.
